// File: rtl/pixel_cache_mem.sv
// 1-bit-per-pixel frame store with a single-line read cache answering (x, y) pixel requests.
// Optional CACHE_WR_UPDATE_EN: writes that hit the cached line (or race its fill) update it instead of invalidating.
module pixel_cache_mem #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic              pixel,
  output logic              ready,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_full;
  logic [ADDR_W-1:0]   cur_addr;
  logic                oof, hit, rd_en;
  logic [7:0]          line_data;
  logic [ADDR_W-1:0]   line_tag;
  logic                line_valid;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                fill_stale;
  logic [7:0]          ram_q;
  logic [7:0]          mem [DEPTH];
  logic                wr_tag_hit, wr_fetch_hit, wr_issue_hit;
`ifdef CACHE_WR_UPDATE_EN
  logic [7:0]          stale_data;
`endif

  always_comb begin
    addr_full = 32'(y) * 32'(IMG_W / 8) + 32'(x[9:3]);
    cur_addr  = addr_full[ADDR_W-1:0];
    oof       = (32'(x) >= IMG_W) || (32'(y) >= IMG_H);
    hit       = line_valid && (line_tag == cur_addr);
    ready     = oof || hit;
    pixel     = !oof && hit && line_data[x[2:0]];
  end

  always_comb begin
    wr_tag_hit   = wr_en && line_valid && (wr_addr == line_tag);
    wr_fetch_hit = wr_en && (wr_addr == fetch_addr);
    wr_issue_hit = wr_en && (wr_addr == cur_addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!oof && !hit) begin
          rd_en   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Simple dual-port RAM; read returns the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) ram_q <= mem[cur_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_data  <= '0;
      line_tag   <= '0;
      line_valid <= 1'b0;
      fetch_addr <= '0;
      fill_stale <= 1'b0;
`ifdef CACHE_WR_UPDATE_EN
      stale_data <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_tag_hit) begin
`ifdef CACHE_WR_UPDATE_EN
            line_data <= wr_data;
`else
            line_valid <= 1'b0;
`endif
          end
          if (rd_en) begin
            fetch_addr <= cur_addr;
            fill_stale <= wr_issue_hit;
`ifdef CACHE_WR_UPDATE_EN
            stale_data <= wr_data;
`endif
          end
        end
        FETCH: begin
          line_tag <= fetch_addr;
`ifdef CACHE_WR_UPDATE_EN
          // A write racing the fill wins over the (older) RAM read data.
          line_valid <= 1'b1;
          if (wr_fetch_hit)    line_data <= wr_data;
          else if (fill_stale) line_data <= stale_data;
          else                 line_data <= ram_q;
`else
          line_data  <= ram_q;
          line_valid <= !(fill_stale || wr_fetch_hit);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_cache_mem.sv
// Randomized self-checking bench for pixel_cache_mem against a cycle-level behavioural cache model.
// Honours CACHE_WR_UPDATE_EN in both the model and the directed coherence expectations.
module tb_pixel_cache_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        pixel, ready;
  logic [7:0]  wr_data;
  logic [15:0] wr_addr;
  logic        wr_en;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Behavioural model: frame bytes, the single cached line, and an in-flight fetch.
  bit [7:0] mem_m [65536];
  bit       m_valid, m_busy, m_stale;
  int       m_tag, m_faddr;
  bit [7:0] m_data, m_snap, m_sdata;
  logic     last_ready, last_pixel;

  pixel_cache_mem #(.IMG_W(640), .IMG_H(480), .ADDR_W(16), .DEPTH(65536)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .pixel(pixel), .ready(ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int addr_of(input int xi, input int yi);
    return (yi * 80 + xi / 8) % 65536;
  endfunction

  function automatic bit out_of_frame(input int xi, input int yi);
    return (xi >= 640) || (yi >= 480);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_stale = 0;
    m_tag = 0; m_faddr = 0; m_data = '0;
  endtask

  task automatic model_edge();
    int a;
    bit o, h, wr_fa;
    a = addr_of(int'(x), int'(y));
    o = out_of_frame(int'(x), int'(y));
    wr_fa = wr_en && (int'(wr_addr) == m_faddr);
    if (m_busy) begin
      m_busy = 0;
      m_tag  = m_faddr;
`ifdef CACHE_WR_UPDATE_EN
      m_valid = 1;
      m_data  = wr_fa ? wr_data : (m_stale ? m_sdata : m_snap);
`else
      m_valid = !(m_stale || wr_fa);
      m_data  = m_snap;
`endif
    end else begin
      h = m_valid && (m_tag == a);
      if (wr_en && m_valid && int'(wr_addr) == m_tag) begin
`ifdef CACHE_WR_UPDATE_EN
        m_data = wr_data;
`else
        m_valid = 0;
`endif
      end
      if (!o && !h) begin
        m_busy  = 1;
        m_faddr = a;
        m_snap  = mem_m[a];
        m_stale = wr_en && (int'(wr_addr) == a);
        m_sdata = wr_data;
      end
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
  endtask

  task automatic compare_outputs();
    bit o, h, er, ep;
    int a;
    a  = addr_of(int'(x), int'(y));
    o  = out_of_frame(int'(x), int'(y));
    h  = m_valid && (m_tag == a);
    er = o || h;
    ep = !o && h && m_data[int'(x) % 8];
    check_val("ready", 32'(ready), 32'(er));
    if (er) check_val("pixel", 32'(pixel), 32'(ep));
    last_ready = ready;
    last_pixel = pixel;
  endtask

  task automatic step(input int xi, input int yi, input bit we, input int wa, input int wd);
    @(negedge clk);
    x = 10'(xi); y = 10'(yi);
    wr_en = we; wr_addr = 16'(wa); wr_data = 8'(wd);
    #1;
    compare_outputs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic req(input int xi, input int yi);
    step(xi, yi, 0, 0, 0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    wr_en = 0;
    reset = 1;
    #1;
    model_reset();
    check_val("reset_mid_ready", 32'(ready), 32'(out_of_frame(int'(x), int'(y))));
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    int cx, cy, wa;
    reset = 1; x = '0; y = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    model_reset();
    #1;
    check_val("reset_ready", 32'(ready), 32'd0);
    x = 10'd640;
    #1;
    check_val("reset_oof_ready", 32'(ready), 32'd1);
    @(negedge clk);
    #2 reset = 0;

    // Preload the exercised region (rows 0..7, bytes 0..7) to zero, then the test image.
    for (int yy = 0; yy < 8; yy++)
      for (int bb = 0; bb < 8; bb++)
        step(640, 0, 1, yy * 80 + bb, 0);
    step(640, 0, 1, 160, 8'h80);
    step(640, 0, 1, 240, 8'h08);
    step(640, 0, 1, 321, 8'h02);
    step(640, 0, 1, 400, 8'h20);

    // Load test: 2-cycle miss then same-cycle neighbour hit.
    req(7, 2); check_val("miss_c0", {last_ready, last_pixel}, 2'b00);
    req(7, 2); check_val("miss_c1", {last_ready, last_pixel}, 2'b00);
    req(7, 2); check_val("miss_c2", {last_ready, last_pixel}, 2'b11);
    req(6, 2); check_val("hit_6_2", {last_ready, last_pixel}, 2'b10);

    req(3, 3); req(3, 3); req(3, 3); check_val("miss_3_3", {last_ready, last_pixel}, 2'b11);
    req(9, 4); req(9, 4); req(9, 4); check_val("miss_9_4", {last_ready, last_pixel}, 2'b11);
    req(5, 5); req(5, 5); req(5, 5); check_val("miss_5_5", {last_ready, last_pixel}, 2'b11);
    req(4, 5); check_val("hit_4_5", {last_ready, last_pixel}, 2'b10);
    req(0, 0); req(0, 0); req(0, 0); check_val("zero_0_0", {last_ready, last_pixel}, 2'b10);

    req(640, 0); check_val("oof_x", {last_ready, last_pixel}, 2'b10);
    req(0, 480); check_val("oof_y", {last_ready, last_pixel}, 2'b10);
    req(1, 0);   check_val("line_kept", {last_ready, last_pixel}, 2'b10);

    // Coherence with (7,2) cached.
    req(7, 2); req(7, 2); req(7, 2);
    step(7, 2, 1, 160, 8'h00); check_val("wr_cycle", {last_ready, last_pixel}, 2'b11);
    req(7, 2);
`ifdef CACHE_WR_UPDATE_EN
    check_val("after_wr", {last_ready, last_pixel}, 2'b10);
`else
    check_val("after_wr", {last_ready, last_pixel}, 2'b00);
`endif
    req(7, 2); req(7, 2); check_val("refetch", {last_ready, last_pixel}, 2'b10);
    step(640, 0, 1, 160, 8'h80);

    // Coordinate change during FETCH.
    req(0, 0); req(0, 0); req(0, 0);
    req(7, 2); check_val("cold_issue", {last_ready, last_pixel}, 2'b00);
    req(9, 4); check_val("switch_fetch", {last_ready, last_pixel}, 2'b00);
    req(9, 4); check_val("switch_miss", {last_ready, last_pixel}, 2'b00);
    req(9, 4);
    req(9, 4); check_val("switch_done", {last_ready, last_pixel}, 2'b11);

    // Reset during FETCH abandons the fill; RAM survives.
    req(5, 5);
    reset_mid();
    req(5, 5); check_val("post_rst_c0", {last_ready, last_pixel}, 2'b00);
    req(5, 5); check_val("post_rst_c1", {last_ready, last_pixel}, 2'b00);
    req(5, 5); check_val("post_rst_c2", {last_ready, last_pixel}, 2'b11);

    // Randomized traffic inside the preloaded region.
    cx = 0; cy = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(15))
          0: begin cx = $urandom_range(1023, 640); cy = $urandom_range(7); end
          1: begin cx = $urandom_range(63); cy = $urandom_range(1023, 480); end
          default: begin cx = $urandom_range(63); cy = $urandom_range(7); end
        endcase
      end
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0 && !out_of_frame(cx, cy)) wa = addr_of(cx, cy);
        else wa = $urandom_range(7) * 80 + $urandom_range(7);
        step(cx, cy, 1, wa, $urandom_range(255));
      end else begin
        req(cx, cy);
      end
      if (i == 300) reset_mid();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
